// File: rtl/pic_irq_arbiter.sv
// 8259A request/priority front end: IRR capture, masking, nested priority resolution and the INTA pair.
// Optional build macro PIC_AUTO_ROTATE_EN adds rotate_en and automatic EOI-driven priority rotation.
module pic_irq_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ir_in,
   input  logic [7:0] imr,
   input  logic [7:0] isr_in,
   input  logic       ltim,
   input  logic       inta,
   input  logic       eoi,
   input  logic [4:0] vector_base,
`ifdef PIC_AUTO_ROTATE_EN
   input  logic       rotate_en,
`endif
   output logic [7:0] irr,
   output logic       int_out,
   output logic [7:0] int_no,
   output logic [7:0] vector,
   output logic       vector_valid
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] WAIT2 = 1'b1;

   logic [0:0] state;
   logic [7:0] ir_prev;
   logic [2:0] win_idx;
   logic [2:0] lowest_prio;

   logic [7:0] new_edge;
   logic [7:0] irr_set;
   logic [7:0] irr_clr;
   logic [7:0] ack_clr;
   logic [7:0] irr_nxt;
   logic [7:0] req;
   logic [3:0] cand;
   logic [3:0] svc;
   logic       cand_v;
   logic [2:0] cand_idx;
   logic       svc_v;
   logic [2:0] svc_idx;
   logic       outranks;
   logic       ack1;
   logic       int_nxt;

   // Returns {found, index} of the highest-priority set bit; priority starts just above lp and wraps.
   function automatic logic [3:0] prio_pick(input logic [7:0] v, input logic [2:0] lp);
      logic [3:0] r;
      logic [2:0] idx;
      r = 4'b0000;
      for (int k = 8; k >= 1; k--) begin
         idx = lp + 3'(k);
         if (v[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   // Rank 0 is the highest priority level for the current rotation.
   function automatic logic [2:0] prio_rank(input logic [2:0] idx, input logic [2:0] lp);
      return idx - lp - 3'd1;
   endfunction

`ifdef PIC_AUTO_ROTATE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lowest_prio <= 3'd7;
      end else if (eoi && rotate_en && svc_v) begin
         lowest_prio <= svc_idx;
      end
   end
`else
   logic unused_eoi;
   assign unused_eoi  = eoi;
   assign lowest_prio = 3'd7;
`endif

   assign req      = irr & ~imr;
   assign cand     = prio_pick(req, lowest_prio);
   assign cand_v   = cand[3];
   assign cand_idx = cand[2:0];
   assign svc      = prio_pick(isr_in, lowest_prio);
   assign svc_v    = svc[3];
   assign svc_idx  = svc[2:0];
   assign outranks = prio_rank(cand_idx, lowest_prio) < prio_rank(svc_idx, lowest_prio);

   assign ack1 = (state == IDLE) && inta && cand_v;

   always_comb begin
      ack_clr = 8'h00;
      if (ack1) ack_clr[cand_idx] = 1'b1;
   end

   // A fresh edge survives a same-cycle clear; a held level does not beat ACK1.
   always_comb begin
      new_edge = ir_in & ~ir_prev;
      irr_set  = ltim ? ir_in : new_edge;
      irr_clr  = ack_clr | (ltim ? ~ir_in : 8'h00);
      irr_nxt  = (irr & ~irr_clr) | (irr_set & ~irr_clr) | (irr_set & new_edge);
   end

   always_comb begin
      int_nxt = 1'b0;
      if ((state == IDLE) && !inta && cand_v)
         int_nxt = (isr_in == 8'h00) || outranks;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ir_prev      <= 8'h00;
         irr          <= 8'h00;
         int_out      <= 1'b0;
         int_no       <= 8'h00;
         vector       <= 8'h00;
         vector_valid <= 1'b0;
         win_idx      <= 3'd7;
      end else begin
         ir_prev      <= ir_in;
         irr          <= irr_nxt;
         int_out      <= int_nxt;
         int_no       <= 8'h00;
         vector_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (inta) begin
                  // With no candidate the acknowledge is spurious and reports IR7.
                  win_idx <= cand_v ? cand_idx : 3'd7;
                  if (cand_v) int_no <= 8'h01 << cand_idx;
                  state <= WAIT2;
               end
            end
            WAIT2: begin
               if (inta) begin
                  vector       <= {vector_base, win_idx};
                  vector_valid <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
